lab4_decoder_seq: RTL and testbench

- Sequential counterpart of the lab4 9-line active-low priority encoder.
- Accepts a 5-bit code {Y4..Y0} through a valid/ready handshake and drives the matching active-low line A0..A8 low for a programmable number of cycles.
- After the hold, enforces a recovery gap, then accepts the next code.
- Sits on the downstream side of the encoder in loopback and board-level tests, so a captured key index can be replayed onto a line bus.

---
 rtl/lab4_decoder_seq.sv | 128 ++++++++++++
 tb/tb_lab4_decoder_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lab4_decoder_seq.sv
// Sequential active-low line driver: accepts a 5-bit code, holds the matching A line low, then idles for a recovery gap.
// Define LAB4_DECODER_ERR_STICKY_EN to make err latch until reset instead of pulsing for one cycle.
module lab4_decoder_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic Y0,
    input  logic Y1,
    input  logic Y2,
    input  logic Y3,
    input  logic Y4,
    output logic A0,
    output logic A1,
    output logic A2,
    output logic A3,
    output logic A4,
    output logic A5,
    output logic A6,
    output logic A7,
    output logic A8,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] NO_LINE   = 5'd16;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [8:0] lines, lines_nxt;
    logic       ready_nxt, busy_nxt, done_nxt, err_nxt;
    logic [4:0] code;
    logic       xfer;

    assign code = {Y4, Y3, Y2, Y1, Y0};
    assign xfer = in_valid && in_ready;
    assign {A8, A7, A6, A5, A4, A3, A2, A1, A0} = lines;

    // The line register doubles as the latched index, so Y* changes after acceptance have no effect.
    function automatic logic [8:0] line_mask(input logic [3:0] idx);
        return ~(9'b1 << idx);
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lines_nxt = lines;
        done_nxt  = 1'b0;
`ifdef LAB4_DECODER_ERR_STICKY_EN
        err_nxt   = err;
`else
        err_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                lines_nxt = '1;
                if (xfer) begin
                    if (code <= 5'd8) begin
                        lines_nxt = line_mask(code[3:0]);
                        cnt_nxt   = HOLD_LOAD;
                        state_nxt = DRIVE;
                    end else if (code != NO_LINE) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt == 8'd0) begin
                    lines_nxt = '1;
                    done_nxt  = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 8'd0;
                    end else begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            GAP: begin
                lines_nxt = '1;
                if (cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                lines_nxt = '1;
                cnt_nxt   = 8'd0;
            end
        endcase
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            lines    <= '1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lines    <= lines_nxt;
            in_ready <= ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_lab4_decoder_seq.sv
// Bench for lab4_decoder_seq: directed scenarios plus random traffic checked against a timing model of the code map.
module tb_lab4_decoder_seq;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready;
    logic Y0, Y1, Y2, Y3, Y4;
    logic A0, A1, A2, A3, A4, A5, A6, A7, A8;
    logic busy, done, err;

    int total = 0;
    int bad   = 0;

    // Model: edge index e plus the edge numbers at which each output changes.
    int e         = 0;
    int low_until = 0;
    int line_sel  = 0;
    int ready_at  = 0;
    int done_at   = -1;
    int err_at    = -1;
    bit err_stk   = 1'b0;

    lab4_decoder_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7), .A8(A8),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [12:0] act;
    assign act = {A8, A7, A6, A5, A4, A3, A2, A1, A0, in_ready, busy, done, err};

    function automatic logic [12:0] expv();
        logic [8:0] l;
        logic       rdy;
        logic       er;
        l = '1;
        if (e < low_until) l[line_sel] = 1'b0;
        rdy = (e >= ready_at);
`ifdef LAB4_DECODER_ERR_STICKY_EN
        er = err_stk;
`else
        er = (err_at == e);
`endif
        return {l, rdy, !rdy, (done_at == e), er};
    endfunction

    task automatic tick(input logic v, input logic [4:0] c, input logic r);
        in_valid = v;
        {Y4, Y3, Y2, Y1, Y0} = c;
        reset = r;
        @(posedge clk);
        e++;
        if (r) begin
            low_until = e;
            ready_at  = e;
            done_at   = -1;
            err_at    = -1;
            err_stk   = 1'b0;
        end else if (v && (e - 1) >= ready_at) begin
            if (c <= 5'd8) begin
                line_sel  = int'(c);
                low_until = e + HOLD;
                done_at   = e + HOLD;
                ready_at  = e + HOLD + GAP;
            end else if (c != 5'd16) begin
                err_at  = e;
                err_stk = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 5'd0, 1'b1);
        tick(1'b0, 5'd0, 1'b1);
        total++;
        if (act !== 13'b1_1111_1111_1000) begin
            bad++;
            $display("FAIL reset_values got=%b want=%b", act, 13'b1_1111_1111_1000);
        end
        tick(1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_single();
        int low_cnt = 0;
        int done_cnt = 0;
        int nrdy_cnt = 0;
        tick(1'b1, 5'd5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL single e=%0d got=%b want=%b", e, act, expv());
            end
            if (!A5) low_cnt++;
            if (done) done_cnt++;
            if (!in_ready) nrdy_cnt++;
            tick(1'b0, 5'd0, 1'b0);
        end
        total++;
        if (low_cnt != HOLD) begin
            bad++;
            $display("FAIL single_low_len got=%0d want=%0d", low_cnt, HOLD);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL single_done_count got=%0d want=1", done_cnt);
        end
        total++;
        if (nrdy_cnt != HOLD + GAP) begin
            bad++;
            $display("FAIL single_busy_len got=%0d want=%0d", nrdy_cnt, HOLD + GAP);
        end
    endtask

    task automatic test_no_line();
        tick(1'b1, 5'd16, 1'b0);
        total++;
        if (act !== 13'b1_1111_1111_1000) begin
            bad++;
            $display("FAIL no_line got=%b want=%b", act, 13'b1_1111_1111_1000);
        end
        tick(1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL no_line_then_0 e=%0d got=%b want=%b", e, act, expv());
            end
            tick(1'b0, 5'd0, 1'b0);
        end
    endtask

    task automatic test_illegal();
        tick(1'b1, 5'd12, 1'b0);
        total++;
        if (act !== 13'b1_1111_1111_1001) begin
            bad++;
            $display("FAIL illegal_first got=%b want=%b", act, 13'b1_1111_1111_1001);
        end
        tick(1'b0, 5'd0, 1'b0);
        tick(1'b1, 5'd3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL illegal_then_3 e=%0d got=%b want=%b", e, act, expv());
            end
            tick(1'b0, 5'd0, 1'b0);
        end
    endtask

    task automatic test_hold_change();
        int a8_low = 0;
        int a2_low = 0;
        tick(1'b1, 5'd8, 1'b0);
        for (int i = 0; i < 14; i++) begin
            logic [4:0] c;
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL hold_change e=%0d got=%b want=%b", e, act, expv());
            end
            if (!A8) a8_low++;
            if (!A2) a2_low++;
            c = (i == 2) ? 5'($urandom_range(0, 31)) : 5'd2;
            tick(i < 6, c, 1'b0);
        end
        total++;
        if (a8_low != HOLD) begin
            bad++;
            $display("FAIL hold_a8_len got=%0d want=%0d", a8_low, HOLD);
        end
        total++;
        if (a2_low != HOLD) begin
            bad++;
            $display("FAIL hold_a2_len got=%0d want=%0d", a2_low, HOLD);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 5'd7, 1'b0);
        tick(1'b0, 5'd0, 1'b0);
        total++;
        if (A7 !== 1'b0) begin
            bad++;
            $display("FAIL mid_drive A7 got=%b want=0", A7);
        end
        tick(1'b0, 5'd0, 1'b1);
        total++;
        if (act !== 13'b1_1111_1111_1000) begin
            bad++;
            $display("FAIL reset_mid got=%b want=%b", act, 13'b1_1111_1111_1000);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 5'd0, 1'b0);
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL reset_mid_after e=%0d got=%b want=%b", e, act, expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [4:0] c;
            logic       v;
            int         lows;
            v = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
            tick(v, c, ($urandom_range(0, 99) == 0));
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL random e=%0d got=%b want=%b", e, act, expv());
            end
            lows = 0;
            for (int b = 4; b < 13; b++) if (act[b] == 1'b0) lows++;
            total++;
            if (lows > 1) begin
                bad++;
                $display("FAIL exclusive e=%0d got=%0d lines low want<=1", e, lows);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        {Y4, Y3, Y2, Y1, Y0} = 5'd0;
        test_reset();
        test_single();
        test_no_line();
        test_illegal();
        test_reset();
        test_hold_change();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
